load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum WAIT cycles without i_mem_ack before fault.
REQ-002 SHALL have ports: i_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_valid  in  1  request valid; i_load, i_store  in  1 each  operation select.
REQ-005 i_funct3  in  3  access size/sign per RV32I load/store encoding.
REQ-006 i_addr  in  32  byte address (ALU add result); i_wdata  in  32  store data, rs2.
REQ-007 o_ready  out  1  high only in IDLE.
REQ-008 o_mem_req  out  1; o_mem_addr  out  32, bits[1:0]=0; o_mem_wen  out  1; o_mem_wmask  out  4; o_mem_wdata  out  32.
REQ-009 i_mem_ack  in  1  memory completion; i_mem_rdata  in  32  read word, valid with ack.
REQ-010 o_done  out  1  one-cycle completion pulse; o_rdata  out  32  load result; o_misaligned, o_timeout  out  1  fault flags, valid with o_done.

Function
REQ-011 SHALL accept a request on an edge where i_valid & o_ready & (i_load ^ i_store); other i_valid cycles ignored.
REQ-012 SHALL capture addr, wdata, funct3, op at accept; later input changes have no effect on that operation.
REQ-013 SHALL implement states IDLE, WAIT, DONE: IDLE->WAIT on legal aligned accept; IDLE->DONE on faulting accept; WAIT->DONE on ack or timeout; DONE->IDLE unconditionally.
REQ-014 Legal load funct3: 000,001,010,100,101; legal store funct3: 000,001,010; any other value SHALL fault as misaligned.
REQ-015 Halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL fault: no o_mem_req, DONE next cycle with o_misaligned=1, o_rdata=0.
REQ-016 o_mem_req SHALL be high for every WAIT cycle; o_mem_addr/wen/wmask/wdata SHALL be registered and stable while o_mem_req high.
REQ-017 Store byte: wdata[7:0] replicated to all four lanes, wmask=0001<<addr[1:0]; halfword: wdata[15:0] in both halves, wmask=0011<<addr[1:0]; word: wmask=1111. Loads: wen=0, wmask=0000.
REQ-018 Load result: lane selected by addr[1:0]; sign-extended for 000/001, zero-extended for 100/101, unchanged for 010; registered into o_rdata on the ack edge.
REQ-019 Store completion SHALL drive o_rdata=0.
REQ-020 Latency: ack sampled on k-th WAIT edge -> o_done high in following cycle; minimum accept-to-o_done is 2 cycles; o_ready returns the cycle after o_done.
REQ-021 Timeout counter SHALL clear at accept and increment each WAIT cycle without ack; reaching TIMEOUT_CYCLES SHALL drop o_mem_req and enter DONE with o_timeout=1, o_rdata=0.
REQ-022 Ack and timeout on same edge: ack wins, o_timeout=0.
REQ-023 i_mem_ack outside WAIT SHALL be ignored.
REQ-024 o_done, o_misaligned, o_timeout SHALL be high only in DONE; all flags zero otherwise.

Reset
REQ-025 On i_rst high at an edge: state IDLE, counter 0, o_mem_req=0, o_mem_wen=0, o_mem_wmask=0, o_mem_addr=0, o_mem_wdata=0, o_done=0, o_rdata=0, o_misaligned=0, o_timeout=0; o_ready=1 in the first cycle after reset.
REQ-026 Reset mid-WAIT SHALL drop o_mem_req on that edge and produce no o_done for the aborted operation.
REQ-027 Reset SHALL override an accept or ack on the same edge.

Structure
REQ-028 Shared package lsu_pkg SHALL hold the state enum, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and mask constants.
REQ-029 Combinational sub-module lsu_align SHALL perform lane replication, mask generation, load extraction/extension and alignment check; FSM and counter stay in load_store_unit.

Verification
REQ-030 LW addr 0x100, ack on first WAIT cycle, rdata 0xDEADBEEF -> o_mem_addr 0x100, wmask 0000, o_done 2 cycles after accept, o_rdata 0xDEADBEEF.
REQ-031 LB addr 0x103, rdata 0x80FF_0000 -> o_rdata 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
REQ-032 SH addr 0x202, wdata 0x1234ABCD -> wdata 0xABCDABCD, wmask 1100, wen 1, o_rdata 0.
REQ-033 LW addr 0x101 -> no o_mem_req, o_done with o_misaligned=1 next cycle; store funct3 100 -> same.
REQ-034 TIMEOUT_CYCLES=4, no ack -> o_mem_req 4 cycles, then o_done with o_timeout=1; ack on 4th edge -> o_timeout=0.
REQ-035 i_rst on 2nd WAIT cycle -> o_mem_req low next cycle, no o_done, o_ready high; late ack ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I funct3 codes
// and byte-lane write-mask constants.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: request alignment check, store lane
// replication and byte mask, and load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_lane,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    misaligned  = 1'b0;
    wmask       = MASK_NONE;
    wdata_lanes = wdata;
    if (is_store) begin
      case (funct3)
        SB: begin
          wdata_lanes = {4{wdata[7:0]}};
          wmask       = MASK_B << addr_lo;
        end
        SH: begin
          wdata_lanes = {2{wdata[15:0]}};
          wmask       = MASK_H << addr_lo;
          misaligned  = addr_lo[0];
        end
        SW: begin
          wmask      = MASK_W;
          misaligned = |addr_lo;
        end
        default: misaligned = 1'b1;
      endcase
    end else begin
      case (funct3)
        LB, LBU: misaligned = 1'b0;
        LH, LHU: misaligned = addr_lo[0];
        LW:      misaligned = |addr_lo;
        default: misaligned = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (rsp_lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = rsp_lane[1] ? rdata[31:16] : rdata[15:0];
    case (rsp_funct3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'b0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'b0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time, issues a single
// memory request, and reports completion, misalignment or timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [3:0]  o_mem_wmask,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_funct3;
  logic [1:0]    op_lane;
  logic          op_store;

  logic          accept;
  logic          fault;
  logic [3:0]    wmask;
  logic [31:0]   wdata_lanes;
  logic [31:0]   load_data;

  assign o_ready   = (state == IDLE);
  assign o_mem_req = (state == WAIT);
  assign accept    = i_valid & o_ready & (i_load ^ i_store);

  lsu_align u_align (
    .funct3      (i_funct3),
    .addr_lo     (i_addr[1:0]),
    .is_store    (i_store),
    .wdata       (i_wdata),
    .rsp_funct3  (op_funct3),
    .rsp_lane    (op_lane),
    .rdata       (i_mem_rdata),
    .misaligned  (fault),
    .wmask       (wmask),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data)
  );

  // Status flags default low every cycle so they can only be seen in DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      op_funct3    <= '0;
      op_lane      <= '0;
      op_store     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wen    <= 1'b0;
      o_mem_wmask  <= '0;
      o_mem_wdata  <= '0;
      o_done       <= 1'b0;
      o_rdata      <= '0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (fault) begin
              state        <= DONE;
              o_done       <= 1'b1;
              o_misaligned <= 1'b1;
              o_rdata      <= '0;
            end else begin
              state       <= WAIT;
              op_funct3   <= i_funct3;
              op_lane     <= i_addr[1:0];
              op_store    <= i_store;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_wen   <= i_store;
              o_mem_wmask <= wmask;
              o_mem_wdata <= wdata_lanes;
            end
          end
        end
        WAIT: begin
          // An ack on the final counted cycle still completes normally.
          if (i_mem_ack) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_rdata <= op_store ? '0 : load_data;
          end else if (cnt == LAST) begin
            state     <= DONE;
            o_done    <= 1'b1;
            o_timeout <= 1'b1;
            o_rdata   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a stimulus process pushes
// expected memory requests and completions, a monitor pops and compares them.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_load, i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_ready, o_mem_req, o_mem_wen;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_done, o_misaligned, o_timeout;
  logic [31:0] o_rdata;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        to;
    int unsigned cyc;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  int unsigned cyc = 0;
  logic        rst_q = 1'b0;
  bit          stim_done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_load       (i_load),
    .i_store      (i_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_ready      (o_ready),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wen    (o_mem_wen),
    .o_mem_wmask  (o_mem_wmask),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_misaligned (o_misaligned),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_q <= i_rst;

  // Reference model: plain arithmetic from the RV32I access rules.
  function automatic int unsigned nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (st && f3 > 3'd2) return 1'b0;
    if (!st && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
    return (a % nbytes(f3)) == 0;
  endfunction

  function automatic logic [3:0] model_wmask(input logic [2:0] f3, input logic [31:0] a);
    int unsigned m;
    m = ((1 << nbytes(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (nbytes(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v, mask;
    int unsigned nb;
    nb = nbytes(f3);
    if (nb == 4) return rd;
    mask = (32'd1 << (8 * nb)) - 1;
    v = (rd >> (8 * (a % 4))) & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  bit          prev_req = 1'b0;
  req_t        snap;
  req_t        er;
  done_t       ed;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_ready", {31'b0, o_ready}, 32'd1);
      chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
      chk("rst_mem_addr", o_mem_addr, 32'd0);
      chk("rst_mem_wdata", o_mem_wdata, 32'd0);
      chk("rst_mem_ctl", {27'b0, o_mem_wen, o_mem_wmask}, 32'd0);
      chk("rst_rdata", o_rdata, 32'd0);
      chk("rst_flags", {29'b0, o_done, o_misaligned, o_timeout}, 32'd0);
      prev_req = 1'b0;
    end else if (cyc > 1) begin
      if (o_mem_req === 1'b1) begin
        chk("req_not_ready", {31'b0, o_ready}, 32'd0);
        if (!prev_req) begin
          if (req_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
          end else begin
            er = req_q.pop_front();
            chk("req_addr", o_mem_addr, er.addr);
            chk("req_ctl", {27'b0, o_mem_wen, o_mem_wmask}, {27'b0, er.wen, er.wmask});
            if (er.wen) chk("req_wdata", o_mem_wdata, er.wdata);
            snap = '{addr: o_mem_addr, wen: o_mem_wen, wmask: o_mem_wmask, wdata: o_mem_wdata};
          end
        end else begin
          chk("req_addr_stable", o_mem_addr, snap.addr);
          chk("req_wdata_stable", o_mem_wdata, snap.wdata);
          chk("req_ctl_stable", {27'b0, o_mem_wen, o_mem_wmask}, {27'b0, snap.wen, snap.wmask});
        end
      end
      if (o_done === 1'b1) begin
        chk("done_not_ready", {31'b0, o_ready}, 32'd0);
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          ed = done_q.pop_front();
          chk("done_cycle", cyc, ed.cyc);
          chk("done_rdata", o_rdata, ed.rdata);
          chk("done_flags", {30'b0, o_misaligned, o_timeout}, {30'b0, ed.mis, ed.to});
        end
      end else begin
        chk("flags_low", {30'b0, o_misaligned, o_timeout}, 32'd0);
      end
      prev_req = (o_mem_req === 1'b1);
    end
    if (stim_done) begin
      chk("req_q_empty", req_q.size(), 32'd0);
      chk("done_q_empty", done_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // Stimulus
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (o_ready !== 1'b1) begin
      n++;
      if (n > 30) begin
        $display("FAIL wait_ready: o_ready=%b required 1 within 30 cycles", o_ready);
        $fatal(1);
      end
      @(negedge clk);
    end
  endtask

  task automatic junk_inputs();
    i_valid  = 1'($urandom);
    i_load   = 1'($urandom);
    i_store  = ~i_load;
    i_funct3 = 3'($urandom);
    i_addr   = $urandom;
    i_wdata  = $urandom;
  endtask

  // k = WAIT edge on which ack is sampled (1..TO), 0 = never acked
  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int unsigned k);
    bit          leg;
    int unsigned len;
    done_t       d;
    wait_ready();
    i_valid   = 1'b1;
    i_load    = ~st;
    i_store   = st;
    i_funct3  = f3;
    i_addr    = a;
    i_wdata   = wd;
    i_mem_ack = 1'b0;
    leg = model_legal(st, f3, a);
    len = (k == 0) ? TO : k;
    if (leg) begin
      req_q.push_back('{addr: a & 32'hFFFF_FFFC, wen: st,
                        wmask: st ? model_wmask(f3, a) : 4'b0000,
                        wdata: model_wdata(f3, wd)});
      d.mis = 1'b0;
      d.to  = (k == 0);
      d.rdata = (st || k == 0) ? 32'd0 : model_load(f3, a, rd);
      d.cyc = cyc + 1 + len;
    end else begin
      d = '{rdata: 32'd0, mis: 1'b1, to: 1'b0, cyc: cyc + 1};
    end
    done_q.push_back(d);
    @(posedge clk);
    #1 junk_inputs();
    if (leg) begin
      for (int unsigned j = 1; j <= len; j++) begin
        @(negedge clk);
        i_mem_ack   = (j == k);
        i_mem_rdata = (j == k) ? rd : $urandom;
        junk_inputs();
      end
    end
    @(negedge clk);
    i_valid     = 1'b0;
    i_mem_ack   = 1'($urandom);
    i_mem_rdata = $urandom;
  endtask

  task automatic reset_mid_wait();
    wait_ready();
    i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0;
    i_funct3 = 3'b010; i_addr = 32'h40; i_mem_ack = 1'b0;
    req_q.push_back('{addr: 32'h40, wen: 1'b0, wmask: 4'b0000, wdata: 32'd0});
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    i_mem_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required stimulus to complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd, rd;
    i_rst = 1'b1; i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0;
    i_funct3 = 3'b010; i_addr = 32'h0; i_wdata = 32'h0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0; i_valid = 1'b0; i_mem_ack = 1'b0;

    do_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 2);
    do_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 3);
    do_txn(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 1);
    do_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
    do_txn(1'b1, 3'b100, 32'h200, 32'h55, 32'h0, 1);
    do_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'hAAAA_5555, 0);
    do_txn(1'b0, 3'b010, 32'h304, 32'h0, 32'hAAAA_5555, TO);
    reset_mid_wait();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        wait_ready();
        i_valid = 1'b1;
        i_load  = 1'($urandom);
        i_store = i_load;
        i_addr  = $urandom;
        @(negedge clk);
        i_valid = 1'b0;
      end
      a  = $urandom;
      wd = $urandom;
      rd = $urandom;
      do_txn(1'($urandom), 3'($urandom), a, wd, rd, $urandom_range(0, TO));
    end

    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 stim_done = 1'b1;
  end

endmodule
